// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, ALU/mux selects, multicycle control states and control vector.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_SUMA  = 2'b00;
  localparam logic [1:0] ALU_RESTA = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] FUENTE_B_REG      = 2'b00;
  localparam logic [1:0] FUENTE_B_CUATRO   = 2'b01;
  localparam logic [1:0] FUENTE_B_EXT      = 2'b10;
  localparam logic [1:0] FUENTE_B_EXT_DESP = 2'b11;

  localparam logic [1:0] FUENTE_PC_ALU    = 2'b00;
  localparam logic [1:0] FUENTE_PC_ALUOUT = 2'b01;
  localparam logic [1:0] FUENTE_PC_SALTO  = 2'b10;

  typedef enum logic [3:0] {
    StRst      = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StRWb      = 4'd8,
    StExecI    = 4'd9,
    StIWb      = 4'd10,
    StBranch   = 4'd11,
    StJump     = 4'd12
  } estado_e;

  typedef struct packed {
    logic       pc_escribir;
    logic       pc_escribir_cond;
    logic       i_o_d;
    logic       mem_leer;
    logic       mem_escribir;
    logic       ir_escribir;
    logic       mem_a_reg;
    logic       destino_reg;
    logic       reg_escribir;
    logic       alu_fuente_a;
    logic [1:0] alu_fuente_b;
    logic [1:0] alu_operacion;
    logic [1:0] fuente_pc;
  } control_t;

endpackage

// File: rtl/decodificador_estados.sv
// Pure combinational decode of the multicycle state into the datapath control vector.
module decodificador_estados
  import mips_pkg::*;
(
  input  estado_e  estado_i,
  output control_t control_o
);

  always_comb begin
    control_o = '0;
    unique case (estado_i)
      StFetch: begin
        control_o.mem_leer      = 1'b1;
        control_o.ir_escribir   = 1'b1;
        control_o.pc_escribir   = 1'b1;
        control_o.alu_fuente_b  = FUENTE_B_CUATRO;
        control_o.alu_operacion = ALU_SUMA;
        control_o.fuente_pc     = FUENTE_PC_ALU;
      end
      StDecode: begin
        control_o.alu_fuente_b  = FUENTE_B_EXT_DESP;
        control_o.alu_operacion = ALU_SUMA;
      end
      StMemAddr, StExecI: begin
        control_o.alu_fuente_a  = 1'b1;
        control_o.alu_fuente_b  = FUENTE_B_EXT;
        control_o.alu_operacion = ALU_SUMA;
      end
      StMemRead: begin
        control_o.mem_leer = 1'b1;
        control_o.i_o_d    = 1'b1;
      end
      StMemWrite: begin
        control_o.mem_escribir = 1'b1;
        control_o.i_o_d        = 1'b1;
      end
      StMemWb: begin
        control_o.reg_escribir = 1'b1;
        control_o.mem_a_reg    = 1'b1;
      end
      StExecR: begin
        control_o.alu_fuente_a  = 1'b1;
        control_o.alu_fuente_b  = FUENTE_B_REG;
        control_o.alu_operacion = ALU_FUNCT;
      end
      StRWb: begin
        control_o.reg_escribir = 1'b1;
        control_o.destino_reg  = 1'b1;
      end
      StIWb: control_o.reg_escribir = 1'b1;
      StBranch: begin
        control_o.alu_fuente_a     = 1'b1;
        control_o.alu_fuente_b     = FUENTE_B_REG;
        control_o.alu_operacion    = ALU_RESTA;
        control_o.pc_escribir_cond = 1'b1;
        control_o.fuente_pc        = FUENTE_PC_ALUOUT;
      end
      StJump: begin
        control_o.pc_escribir = 1'b1;
        control_o.fuente_pc   = FUENTE_PC_SALTO;
      end
      default: control_o = '0;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control FSM: state register, next-state, retired count and sticky bad-opcode flag.
module unidad_control_multiciclo
  import mips_pkg::*;
#(
  parameter int unsigned ANCHO_CNT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           codigo_operacion,
  input  logic                 cero,
  input  logic                 mem_listo,
  output logic                 pc_carga,
  output logic                 i_o_d,
  output logic                 mem_leer,
  output logic                 mem_escribir,
  output logic                 ir_escribir,
  output logic                 mem_a_reg,
  output logic                 destino_reg,
  output logic                 reg_escribir,
  output logic                 alu_fuente_a,
  output logic [1:0]           alu_fuente_b,
  output logic [1:0]           alu_operacion,
  output logic [1:0]           fuente_pc,
  output logic [3:0]           estado,
  output logic                 opcode_invalido,
  output logic [ANCHO_CNT-1:0] instr_completadas
);

  estado_e                estado_q, estado_d;
  logic                   arranque_q;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic                   invalido_q, invalido_d;
  logic                   retiro;
  control_t               control;

  always_comb begin
    estado_d   = estado_q;
    invalido_d = invalido_q;
    retiro     = 1'b0;
    unique case (estado_q)
      // Held one extra cycle after reset release so FETCH lands on the 2nd edge.
      StRst:   if (arranque_q) estado_d = StFetch;
      StFetch: if (mem_listo) estado_d = StDecode;
      StDecode: begin
        unique case (codigo_operacion)
          OP_R:         estado_d = StExecR;
          OP_LW, OP_SW: estado_d = StMemAddr;
          OP_ADDI:      estado_d = StExecI;
          OP_BEQ:       estado_d = StBranch;
          OP_J:         estado_d = StJump;
          default: begin
            estado_d   = StFetch;
            invalido_d = 1'b1;
          end
        endcase
      end
      StMemAddr: estado_d = (codigo_operacion == OP_SW) ? StMemWrite : StMemRead;
      StMemRead: if (mem_listo) estado_d = StMemWb;
      StMemWrite: begin
        if (mem_listo) begin
          retiro   = 1'b1;
          estado_d = StFetch;
        end
      end
      StExecR: estado_d = StRWb;
      StExecI: estado_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump: begin
        retiro   = 1'b1;
        estado_d = StFetch;
      end
      default: estado_d = StRst;
    endcase
    cnt_d = retiro ? cnt_q + ANCHO_CNT'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= StRst;
      arranque_q <= 1'b0;
      cnt_q      <= '0;
      invalido_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      arranque_q <= 1'b1;
      cnt_q      <= cnt_d;
      invalido_q <= invalido_d;
    end
  end

  decodificador_estados u_decodificador (
    .estado_i  (estado_q),
    .control_o (control)
  );

  // FETCH's PC/IR loads only take effect on the cycle memory delivers the word.
  assign pc_carga = (control.pc_escribir & ((estado_q != StFetch) | mem_listo)) |
                    (control.pc_escribir_cond & cero);
  assign ir_escribir       = control.ir_escribir & mem_listo;
  assign i_o_d             = control.i_o_d;
  assign mem_leer          = control.mem_leer;
  assign mem_escribir      = control.mem_escribir;
  assign mem_a_reg         = control.mem_a_reg;
  assign destino_reg       = control.destino_reg;
  assign reg_escribir      = control.reg_escribir;
  assign alu_fuente_a      = control.alu_fuente_a;
  assign alu_fuente_b      = control.alu_fuente_b;
  assign alu_operacion     = control.alu_operacion;
  assign fuente_pc         = control.fuente_pc;
  assign estado            = estado_q;
  assign opcode_invalido   = invalido_q;
  assign instr_completadas = cnt_q;

endmodule
